// File: rtl/apb_pkg.sv
// Shared types and default parameters for the APB command master.
// Holds the transfer FSM state type and a counter-width helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_t;

   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned TIMEOUT_DEF    = 16;

   // Wait counter width; a disabled timeout still keeps one bit.
   function automatic int unsigned cnt_bits(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
module apb_cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses a push even when a pop happens on the same edge.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// Queues commands and issues them one at a time as APB4 transfers.
// Ports: PCLK/PRESET, cmd_* in, rsp_* out, busy, APB master signals.
import apb_pkg::*;

module apb_cmd_master #(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
   localparam int unsigned STRB_W    = DATA_W / 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_strb,
   input  logic [2:0]        cmd_prot,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic [STRB_W-1:0] PSTRB,
   output logic [2:0]        PPROT,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int unsigned CW = cnt_bits(TIMEOUT);
   localparam int unsigned FW = 1 + 3 + STRB_W + DATA_W + ADDR_W;

   apb_state_t        state, state_d;
   logic [CW-1:0]     cnt, cnt_d, cnt_inc;
   logic              queued_q;
   logic              pop;
   logic              fifo_full, fifo_empty;
   logic [FW-1:0]     head;
   logic              h_write;
   logic [2:0]        h_prot;
   logic [STRB_W-1:0] h_strb;
   logic [DATA_W-1:0] h_wdata;
   logic [ADDR_W-1:0] h_addr;

   logic              psel_d, penable_d, pwrite_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d;
   logic [STRB_W-1:0] pstrb_d;
   logic [2:0]        pprot_d;
   logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [DATA_W-1:0] rsp_rdata_d;

   assign cmd_ready = !fifo_full && !PRESET;

   apb_cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (PCLK),
      .rst   (PRESET),
      .push  (cmd_valid && cmd_ready),
      .din   ({cmd_write, cmd_prot, cmd_strb, cmd_wdata, cmd_addr}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {h_write, h_prot, h_strb, h_wdata, h_addr} = head;

   assign busy    = !fifo_empty || (state != IDLE) || rsp_valid;
   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      pop           = 1'b0;
      psel_d        = PSEL;
      penable_d     = PENABLE;
      pwrite_d      = PWRITE;
      paddr_d       = PADDR;
      pwdata_d      = PWDATA;
      pstrb_d       = PSTRB;
      pprot_d       = PPROT;
      rsp_valid_d   = rsp_valid;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      rsp_rdata_d   = rsp_rdata;

      if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;

      unique case (state)
         IDLE: begin
            // Launch only from the registered view of the queue, which
            // puts PSEL two edges after a command lands in an empty FIFO.
            if (queued_q && !fifo_empty && (!rsp_valid || rsp_ready)) begin
               pop       = 1'b1;
               state_d   = SETUP;
               cnt_d     = '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = h_write;
               paddr_d   = h_addr;
               pprot_d   = h_prot;
               pwdata_d  = h_write ? h_wdata : '0;
               pstrb_d   = h_write ? h_strb : '0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            cnt_d     = '0;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (PREADY) begin
               state_d       = IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               pstrb_d       = '0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = PWRITE ? '0 : PRDATA;
            end else if (TIMEOUT != 0 && cnt_inc == CW'(TIMEOUT)) begin
               state_d       = IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               pstrb_d       = '0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         cnt         <= '0;
         queued_q    <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         PPROT       <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         queued_q    <= !fifo_empty;
         PSEL        <= psel_d;
         PENABLE     <= penable_d;
         PWRITE      <= pwrite_d;
         PADDR       <= paddr_d;
         PWDATA      <= pwdata_d;
         PSTRB       <= pstrb_d;
         PPROT       <= pprot_d;
         rsp_valid   <= rsp_valid_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
         rsp_rdata   <= rsp_rdata_d;
      end
   end

endmodule
